// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV-M multiply/divide unit for the execute stage.
// A shift-add multiplier and a restoring divider share one accumulator pair and
// retire one bit per cycle. Divide-by-zero and signed overflow are resolved
// directly at accept, so those operations never enter the BUSY phase.
module cpu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q;
  logic [2:0]      op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN:0]   hi_q;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier bits / dividend-quotient bits
  logic [XLEN-1:0] opnd_q;    // multiplicand / divisor magnitude
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] res_q;

  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Decode the incoming request: operand signedness, magnitudes, special cases
  always_comb begin
    a_signed    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_signed    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sign_a      = a_signed && src_a_i[XLEN-1];
    sign_b      = b_signed && src_b_i[XLEN-1];
    mag_a       = sign_a ? -src_a_i : src_a_i;
    mag_b       = sign_b ? -src_b_i : src_b_i;
    div_zero    = (src_b_i == '0);
    div_ovf     = ((op_i == 3'b100) || (op_i == 3'b110)) && (src_a_i == MIN_NEG) && (src_b_i == '1);
    special     = op_i[2] && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? src_a_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : src_a_i;
    end
  end

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum, mul_hi_nx, rem_shift, rem_diff, div_hi_nx;
  logic [XLEN-1:0]   mul_lo_nx, div_lo_nx, quot_s, rem_s, mul_res, div_res, fin_res;
  logic              q_bit;
  logic [2*XLEN-1:0] product, product_s;

  // One iteration step of both algorithms plus sign correction of the final step
  always_comb begin
    // hi_q[XLEN] is always zero while multiplying, so the full register can feed the adder
    addend    = lo_q[0] ? opnd_q : '0;
    mul_sum   = hi_q + {1'b0, addend};
    mul_hi_nx = {1'b0, mul_sum[XLEN:1]};
    mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    // The shifted partial remainder needs XLEN+1 bits; after restoring it fits in XLEN again
    rem_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    q_bit     = (rem_shift >= {1'b0, opnd_q});
    rem_diff  = rem_shift - {1'b0, opnd_q};
    div_hi_nx = q_bit ? rem_diff : rem_shift;
    div_lo_nx = {lo_q[XLEN-2:0], q_bit};
    product   = {mul_hi_nx[XLEN-1:0], mul_lo_nx};
    product_s = (sign_a_q ^ sign_b_q) ? -product : product;
    mul_res   = (op_q[1:0] == 2'b00) ? product_s[XLEN-1:0] : product_s[2*XLEN-1:XLEN];
    quot_s    = (sign_a_q ^ sign_b_q) ? -div_lo_nx : div_lo_nx;
    rem_s     = sign_a_q ? -div_hi_nx[XLEN-1:0] : div_hi_nx[XLEN-1:0];
    div_res   = op_q[1] ? rem_s : quot_s;
    fin_res   = op_q[2] ? div_res : mul_res;
  end

  // Control FSM, operand capture, iteration and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_q     <= op_i;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            if (special) begin
              res_q   <= special_res;
              state_q <= S_DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= op_i[2] ? mag_a : mag_b;
              opnd_q  <= op_i[2] ? mag_b : mag_a;
              cnt_q   <= CW'(XLEN-1);
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_q <= op_q[2] ? div_hi_nx : mul_hi_nx;
          lo_q <= op_q[2] ? div_lo_nx : mul_lo_nx;
          if (cnt_q == '0) begin
            res_q   <= fin_res;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (ready_i) begin
            res_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign res_o   = valid_o ? res_q : '0;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Testbench for cpu_muldiv: directed vectors on an XLEN=32 and an XLEN=8 instance.
// Expected results are queued at accept and compared by per-instance monitors.
module tb_cpu_muldiv;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;

  logic        valid_i32 = 1'b0, flush32 = 1'b0, ready_i32 = 1'b1;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready_o32, valid_o32;
  logic [31:0] res_o32;

  logic        valid_i8 = 1'b0, flush8 = 1'b0, ready_i8 = 1'b1;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready_o8, valid_o8;
  logic [7:0]  res_o8;

  int          total = 0;
  int          passed = 0;
  logic [31:0] sb32 [$];
  string       nm32 [$];
  logic [7:0]  sb8 [$];
  string       nm8 [$];

  logic [2:0] vec_op [16] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM, OP_DIVU, OP_REMU,
                              OP_DIV, OP_REM, OP_DIVU, OP_REM, OP_MULHU, OP_DIVU, OP_MULH, OP_REM};
  logic [7:0] vec_a [16]  = '{8'h07, 8'h07, 8'hFF, 8'hFF, 8'hF9, 8'hF9, 8'h64, 8'h64,
                              8'h80, 8'h80, 8'h05, 8'h05, 8'hC8, 8'h80, 8'h80, 8'h85};
  logic [7:0] vec_b [16]  = '{8'hFD, 8'hFD, 8'hFF, 8'h02, 8'h02, 8'h02, 8'h07, 8'h07,
                              8'hFF, 8'hFF, 8'h00, 8'h00, 8'h64, 8'hFF, 8'h80, 8'h07};

  cpu_muldiv #(.XLEN(32)) u_dut32 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i32), .ready_o(ready_o32), .op_i(op32),
    .src_a_i(a32), .src_b_i(b32), .flush_i(flush32), .valid_o(valid_o32), .ready_i(ready_i32),
    .res_o(res_o32)
  );

  cpu_muldiv #(.XLEN(8)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i8), .ready_o(ready_o8), .op_i(op8),
    .src_a_i(a8), .src_b_i(b8), .flush_i(flush8), .valid_o(valid_o8), .ready_i(ready_i8),
    .res_o(res_o8)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RV-M reference for the 8-bit instance
  function automatic logic [7:0] model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit     sgn_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    bit     sgn_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    longint la = sgn_a ? longint'($signed(a)) : longint'(a);
    longint lb = sgn_b ? longint'($signed(b)) : longint'(b);
    longint r;
    if (!op[2]) begin
      r = la * lb;
      return (op == 3'b000) ? r[7:0] : r[15:8];
    end
    if (b == 8'h00) return op[1] ? a : 8'hFF;
    if (sgn_a && a == 8'h80 && b == 8'hFF) return op[1] ? 8'h00 : a;
    r = op[1] ? (la % lb) : (la / lb);
    return r[7:0];
  endfunction

  function automatic bit is_special8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    return op[2] && ((b == 8'h00) || (((op == 3'b100) || (op == 3'b110)) && a == 8'h80 && b == 8'hFF));
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Issue one request; queue its expected result at the accept edge, then scramble inputs
  task automatic applyStimulus(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input string nm, input bit push);
    int k = 0;
    while (!(w8 ? ready_o8 : ready_o32) && k < 100) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (k >= 100) begin
      total++;
      $display("[TB] FAIL %s ready_o timeout: got 0, expected 1", nm);
    end
    if (w8) begin valid_i8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin valid_i32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    @(posedge clk_i);
    if (push && w8) begin sb8.push_back(exp[7:0]); nm8.push_back(nm); end
    if (push && !w8) begin sb32.push_back(exp); nm32.push_back(nm); end
    #1;
    if (w8) begin valid_i8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
    else begin valid_i32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom; end
  endtask

  // Count edges from the accept edge until valid_o is seen, bounded
  task automatic waitResult(input bit w8, output int lat);
    lat = 1;
    while (!(w8 ? valid_o8 : valid_o32) && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic runVec(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm, input int exp_lat);
    int lat;
    applyStimulus(w8, op, a, b, exp, nm, 1'b1);
    waitResult(w8, lat);
    checkOutput({nm, " latency"}, lat, exp_lat);
    @(posedge clk_i); #1;
  endtask

  // Scoreboard monitor for the 32-bit instance: compare on each accepted result
  always @(negedge clk_i) begin
    if (rst_ni && valid_o32 && ready_i32 && !flush32) begin
      if (sb32.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected32: got result 0x%0h, expected none", res_o32);
      end else begin
        checkOutput(nm32.pop_front(), {32'b0, res_o32}, {32'b0, sb32.pop_front()});
      end
    end
  end

  // Scoreboard monitor for the 8-bit instance
  always @(negedge clk_i) begin
    if (rst_ni && valid_o8 && ready_i8 && !flush8) begin
      if (sb8.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected8: got result 0x%0h, expected none", res_o8);
      end else begin
        checkOutput(nm8.pop_front(), {56'b0, res_o8}, {56'b0, sb8.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    logic [7:0] e8;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset ready_o32", ready_o32, 1);
    checkOutput("reset valid_o32", valid_o32, 0);
    checkOutput("reset res_o32", res_o32, 0);
    checkOutput("reset ready_o8", ready_o8, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    runVec(0, OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "MUL 7*-3", 33);
    runVec(0, OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, "MULH 7*-3", 33);
    runVec(0, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max*max", 33);
    runVec(0, OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "MULHSU -1*2", 33);
    runVec(0, OP_MULHU,  32'h80000000, 32'd4,        32'd2,        "MULHU 2^31*4", 33);
    runVec(0, OP_MUL,    32'h12345678, 32'h10,       32'h23456780, "MUL shift", 33);
    runVec(0, OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "DIV -7/2", 33);
    runVec(0, OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "REM -7/2", 33);
    runVec(0, OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "DIV 7/-2", 33);
    runVec(0, OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        "REM 7/-2", 33);
    runVec(0, OP_DIVU,   32'd100,      32'd7,        32'd14,       "DIVU 100/7", 33);
    runVec(0, OP_REMU,   32'd100,      32'd7,        32'd2,        "REMU 100/7", 33);
    runVec(0, OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "DIVU 5/0", 1);
    runVec(0, OP_REM,    32'd5,        32'd0,        32'd5,        "REM 5/0", 1);
    runVec(0, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV ovf", 1);
    runVec(0, OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        "REM ovf", 1);
    runVec(0, OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        "DIVU 2^31/max", 33);
    runVec(0, OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, "REMU 2^31/max", 33);

    // Hold the consumer off in DONE while a new request waits
    ready_i32 = 1'b0;
    applyStimulus(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "hold MULHU", 1'b1);
    waitResult(0, lat);
    checkOutput("hold latency", lat, 33);
    valid_i32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      checkOutput("hold valid_o", valid_o32, 1);
      checkOutput("hold res_o", res_o32, 32'hFFFFFFFE);
      checkOutput("hold ready_o", ready_o32, 0);
    end
    ready_i32 = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("handshake ready_o", ready_o32, 1);
    checkOutput("handshake valid_o", valid_o32, 0);
    @(posedge clk_i);
    sb32.push_back(32'd14); nm32.push_back("held-request DIVU");
    #1;
    checkOutput("held-request accept ready_o", ready_o32, 0);
    valid_i32 = 1'b0;
    waitResult(0, lat);
    checkOutput("held-request latency", lat, 33);
    @(posedge clk_i); #1;

    // Flush in BUSY cycle 5
    applyStimulus(0, OP_MUL, 32'd7, 32'hFFFFFFFD, 32'd0, "flush busy", 1'b0);
    repeat (4) @(posedge clk_i);
    #1; flush32 = 1'b1;
    @(posedge clk_i); #1; flush32 = 1'b0;
    checkOutput("flush busy ready_o", ready_o32, 1);
    checkOutput("flush busy valid_o", valid_o32, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o32) seen++;
    end
    checkOutput("flush busy no result", seen, 0);

    // Flush together with ready_i in DONE drops the result
    ready_i32 = 1'b0;
    applyStimulus(0, OP_DIVU, 32'd5, 32'd0, 32'd0, "flush done", 1'b0);
    waitResult(0, lat);
    checkOutput("flush done valid_o before", valid_o32, 1);
    flush32 = 1'b1; ready_i32 = 1'b1;
    @(posedge clk_i); #1; flush32 = 1'b0;
    checkOutput("flush done valid_o", valid_o32, 0);
    checkOutput("flush done res_o", res_o32, 0);
    checkOutput("flush done ready_o", ready_o32, 1);

    // Asynchronous reset in the middle of BUSY
    applyStimulus(0, OP_DIVU, 32'd100, 32'd7, 32'd0, "reset victim", 1'b0);
    repeat (3) @(posedge clk_i);
    #2; rst_ni = 1'b0;
    #1;
    checkOutput("async reset ready_o", ready_o32, 1);
    checkOutput("async reset valid_o", valid_o32, 0);
    checkOutput("async reset res_o", res_o32, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    runVec(0, OP_REMU, 32'd100, 32'd7, 32'd2, "REMU after reset", 33);

    // XLEN=8 instance against the reference model
    for (int i = 0; i < 16; i++) begin
      e8 = model8(vec_op[i], vec_a[i], vec_b[i]);
      runVec(1, vec_op[i], {24'b0, vec_a[i]}, {24'b0, vec_b[i]}, {24'b0, e8},
             $sformatf("x8 vec%0d", i), is_special8(vec_op[i], vec_a[i], vec_b[i]) ? 1 : 9);
    end

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("scoreboard32 drained", sb32.size(), 0);
    checkOutput("scoreboard8 drained", sb8.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_muldiv.md
# cpu_muldiv

Iterative, parametrised RV-M multiply/divide unit sitting beside the single-cycle integer ALU in the execute stage. Accepts one operation through a valid/ready handshake and computes it over XLEN iterations with a shift-add multiplier or restoring divider. Holds the result until the consumer takes it. Covers all eight RISC-V M-extension operations, including the defined divide-by-zero and signed-overflow results.

## Interface
- XLEN, 32: operand/result width; any value ≥ 4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  RISC-V funct3: MUL(000) MULH(001) MULHSU(010) MULHU(011) DIV(100) DIVU(101) REM(110) REMU(111).
- src_a_i  in  XLEN  rs1 operand (multiplicand / dividend).
- src_b_i  in  XLEN  rs2 operand (multiplier / divisor).
- flush_i  in  1  abort any operation in progress and discard any held result.
- valid_o  out  1  res_o holds a completed result.
- ready_i  in  1  consumer accepts res_o.
- res_o  out  XLEN  result.

## Operation
- States: IDLE, BUSY, DONE.
- Accept occurs on a rising edge with valid_i && ready_o. op_i and both operands are captured, and inputs are ignored afterwards.
- Signedness:
  - src_a is signed for MULH, MULHSU, DIV and REM.
  - src_b is signed for MULH, DIV and REM.
  - MUL's low half does not depend on signedness.
  - Signed operands are converted to magnitudes on accept.
  - The result sign is applied on the transition to DONE:
    - product sign = sign_a XOR sign_b;
    - quotient sign = sign_a XOR sign_b;
    - remainder sign = sign_a.
- Multiply:
  - 2·XLEN-bit product accumulator, one multiplier bit per BUSY cycle, LSB first.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits of the signed-corrected 2·XLEN product.
- Divide: restoring algorithm, one quotient bit per BUSY cycle, MSB first, with an XLEN+1-bit partial remainder.
- Special cases are resolved at accept and go IDLE→DONE directly, with no BUSY phase:
  - divisor == 0: DIV/DIVU return all ones; REM/REMU return src_a.
  - signed overflow (src_a = 1 followed by XLEN-1 zeros, src_b = all ones) for DIV: result = src_a. For REM: result = 0.
- Transitions:
  - IDLE→BUSY on a normal accept; iteration counter loaded with XLEN-1.
  - BUSY: decrement the counter each cycle; after the cycle in which the counter is 0, go to DONE.
  - DONE: valid_o = 1 and res_o stable. On an edge with ready_i, go to IDLE.
  - flush_i from any state goes to IDLE on the next edge, with valid_o = 0. flush_i has priority over accept and over ready_i.
- No back-to-back accept from DONE. ready_o rises only once the unit is in IDLE.

## Timing
- Reset values: state IDLE, ready_o 1, valid_o 0, res_o 0. Internal accumulators and counter are cleared.
- Reset mid-operation aborts immediately and asynchronously. No result is produced.
- Normal op accepted at edge 0: BUSY for edges 1..XLEN; valid_o high after edge XLEN+1. Latency is XLEN+1 cycles; at XLEN=32 that is 33 cycles.
- Special case accepted at edge 0: valid_o high after edge 1.
- res_o is combinationally stable from DONE entry until the handshake. res_o is 0 whenever valid_o = 0.
- ready_o and valid_o are registered-state decodes, with no combinational path from any input.
- Throughput: at most one op per XLEN+2 cycles when ready_i is held high.

## Test plan
- MUL 7×(-3), XLEN=32 -> res_o 0xFFFFFFEB after 33 cycles. MULH of the same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1×2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with valid_o 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Hold ready_i low for 10 cycles in DONE -> valid_o and res_o remain stable. ready_o stays 0 with valid_i high. Release ready_i -> next op accepted 1 cycle later.
- flush_i at BUSY cycle 5 -> valid_o never asserts and ready_o is 1 next cycle. Assert flush_i with ready_i in DONE -> result dropped.
- rst_ni low mid-BUSY -> outputs at reset values immediately. Repeat the MUL/DIV vectors with XLEN=8 and check them against a reference model.
